// File: rtl/mem_host_initiator.sv
// Host-side master for the memory-controller bus: turns valid/ready byte requests into single
// bus cycles and sequences BIST runs with a timeout. BIST_TIMEOUT must fit in TO_W bits.
module mem_host_initiator #(
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned BIST_TIMEOUT = 200000,
  parameter int unsigned TO_W         = 18
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  input  logic        BIST_REQ,
  input  logic [2:0]  BIST_MODE_IN,
  output logic        BIST_BUSY,
  output logic        BIST_DONE,
  output logic        BIST_OK,
  output logic [15:0] ADDR,
  output logic        CE,
  output logic        CSB,
  output logic        WEB,
  output logic        OEB,
  output logic [7:0]  IDATA,
  input  logic [7:0]  ODATA,
  output logic        BIST_EN,
  output logic [2:0]  BIST_MODE,
  input  logic        BIST_PASS
);

  localparam logic [2:0]      LatSample = 3'(READ_LAT - 1);
  localparam logic [2:0]      LatDone   = 3'(READ_LAT);
  localparam logic [TO_W-1:0] ToLast    = TO_W'(BIST_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRwait,
    StBistRun,
    StBistEnd
  } state_e;

  state_e          state_q;
  logic            ready_q;
  logic [2:0]      lat_cnt_q;
  logic [TO_W-1:0] to_cnt_q;

  // A same-cycle BIST_REQ takes priority, so it must also withdraw the ready.
  assign REQ_READY = ready_q & ~BIST_REQ;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      lat_cnt_q <= '0;
      to_cnt_q  <= '0;
      ADDR      <= '0;
      IDATA     <= '0;
      CE        <= 1'b0;
      CSB       <= 1'b1;
      WEB       <= 1'b1;
      OEB       <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      BIST_EN   <= 1'b0;
      BIST_MODE <= '0;
      BIST_BUSY <= 1'b0;
      BIST_DONE <= 1'b0;
      BIST_OK   <= 1'b0;
    end else begin
      ADDR      <= '0;
      IDATA     <= '0;
      CE        <= 1'b0;
      CSB       <= 1'b1;
      WEB       <= 1'b1;
      OEB       <= 1'b1;
      RSP_VALID <= 1'b0;
      BIST_DONE <= 1'b0;
      ready_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (BIST_REQ) begin
            state_q   <= StBistRun;
            BIST_MODE <= BIST_MODE_IN;
            BIST_EN   <= 1'b1;
            BIST_BUSY <= 1'b1;
            BIST_OK   <= 1'b0;
            to_cnt_q  <= '0;
          end else if (REQ_VALID && ready_q) begin
            ADDR <= REQ_ADDR;
            CE   <= 1'b1;
            CSB  <= 1'b0;
            if (REQ_WE) begin
              state_q <= StWr;
              WEB     <= 1'b0;
              IDATA   <= REQ_WDATA;
            end else begin
              state_q <= StRd;
              OEB     <= 1'b0;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        StWr: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        StRd: begin
          state_q   <= StRwait;
          CSB       <= 1'b0;
          OEB       <= 1'b0;
          lat_cnt_q <= '0;
        end
        StRwait: begin
          if (lat_cnt_q == LatDone) begin
            state_q   <= StIdle;
            RSP_VALID <= 1'b1;
            ready_q   <= 1'b1;
          end else begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
            if (lat_cnt_q == LatSample) begin
              RSP_RDATA <= ODATA;
            end else begin
              CSB <= 1'b0;
              OEB <= 1'b0;
            end
          end
        end
        StBistRun: begin
          // to_cnt_q is zero only in the first run cycle, where BIST_PASS is not trusted yet.
          if (to_cnt_q != '0 && BIST_PASS) begin
            state_q   <= StBistEnd;
            BIST_OK   <= 1'b1;
            BIST_EN   <= 1'b0;
            BIST_BUSY <= 1'b0;
            BIST_DONE <= 1'b1;
          end else if (to_cnt_q == ToLast) begin
            state_q   <= StBistEnd;
            BIST_OK   <= 1'b0;
            BIST_EN   <= 1'b0;
            BIST_BUSY <= 1'b0;
            BIST_DONE <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        StBistEnd: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_host_initiator.sv
// Self-checking bench for mem_host_initiator: directed scenarios plus randomized traffic checked
// against a transaction-level memory/BIST reference model.
module tb_mem_host_initiator;

  localparam int LAT = 1;
  localparam int TMO = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID, REQ_READY, REQ_WE;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        RSP_VALID;
  logic [7:0]  RSP_RDATA;
  logic        BIST_REQ;
  logic [2:0]  BIST_MODE_IN;
  logic        BIST_BUSY, BIST_DONE, BIST_OK;
  logic [15:0] ADDR;
  logic        CE, CSB, WEB, OEB;
  logic [7:0]  IDATA, ODATA;
  logic        BIST_EN;
  logic [2:0]  BIST_MODE;
  logic        BIST_PASS;

  mem_host_initiator #(.READ_LAT(LAT), .BIST_TIMEOUT(TMO), .TO_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .BIST_REQ(BIST_REQ), .BIST_MODE_IN(BIST_MODE_IN),
    .BIST_BUSY(BIST_BUSY), .BIST_DONE(BIST_DONE), .BIST_OK(BIST_OK),
    .ADDR(ADDR), .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB),
    .IDATA(IDATA), .ODATA(ODATA),
    .BIST_EN(BIST_EN), .BIST_MODE(BIST_MODE), .BIST_PASS(BIST_PASS)
  );

  always #5 CLK = ~CLK;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          cyc = 0;

  // Reference memory (updated at accepted writes) and the bus-side memory the bench drives.
  bit [7:0]  ref_mem [65536];
  bit        ref_wr  [65536];
  bit [7:0]  dev_mem [65536];
  bit        dev_wr  [65536];
  bit [15:0] rd_addr;

  function automatic logic [7:0] fill_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : fill_byte(a);
  endfunction

  always @(posedge CLK) begin
    if (!CSB && CE && !WEB) begin
      dev_mem[ADDR] <= IDATA;
      dev_wr[ADDR]  <= 1'b1;
    end
    if (!CSB && CE && WEB && !OEB) rd_addr <= ADDR;
  end
  assign ODATA = OEB ? 8'h00 : (dev_wr[rd_addr] ? dev_mem[rd_addr] : fill_byte(rd_addr));

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (REQ_READY !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (REQ_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_wait: REQ_READY=%b, wanted 1", tag, REQ_READY);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    wait_ready("wr");
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = a; REQ_WDATA = d;
    tick();
    REQ_VALID = 1'b0; REQ_ADDR = 16'($urandom); REQ_WDATA = 8'($urandom);
    vectors++;
    if ({CE, CSB, WEB, OEB, ADDR, IDATA, REQ_READY, RSP_VALID} !== {4'b1001, a, d, 2'b00}) begin
      miscompares++;
      $display("FAIL wr_cycle: got ce/csb/web/oeb=%b addr=%h idata=%h rdy=%b rsp=%b want 1001 %h %h 0 0",
               {CE, CSB, WEB, OEB}, ADDR, IDATA, REQ_READY, RSP_VALID, a, d);
    end
    ref_mem[a] = d;
    ref_wr[a]  = 1'b1;
    tick();
    vectors++;
    if ({CE, CSB, WEB, OEB, ADDR, IDATA, REQ_READY} !== {4'b0111, 16'h0, 8'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL wr_after: got bus=%b addr=%h idata=%h rdy=%b want 0111 0000 00 1",
               {CE, CSB, WEB, OEB}, ADDR, IDATA, REQ_READY);
    end
  endtask

  task automatic do_read(input logic [15:0] a);
    int m = 0;
    logic [7:0] exp;
    exp = exp_rd(a);
    wait_ready("rd");
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = a; REQ_WDATA = 8'($urandom);
    tick();
    REQ_VALID = 1'b0; REQ_ADDR = 16'($urandom);
    vectors++;
    if ({CE, CSB, WEB, OEB, ADDR, REQ_READY, RSP_VALID} !== {4'b1010, a, 2'b00}) begin
      miscompares++;
      $display("FAIL rd_cycle: got bus=%b addr=%h rdy=%b rsp=%b want 1010 %h 0 0",
               {CE, CSB, WEB, OEB}, ADDR, REQ_READY, RSP_VALID, a);
    end
    while (RSP_VALID !== 1'b1 && m < 20) begin
      tick();
      m++;
      if (m <= LAT) begin
        vectors++;
        if ({CE, CSB, WEB, OEB, REQ_READY} !== 5'b00100) begin
          miscompares++;
          $display("FAIL rd_wait: cycle %0d got bus=%b rdy=%b want 0010 0", m, {CE, CSB, WEB, OEB},
                   REQ_READY);
        end
      end
    end
    vectors++;
    if (m != LAT + 2) begin
      miscompares++;
      $display("FAIL rd_latency: got %0d cycles want %0d", m, LAT + 2);
    end
    vectors++;
    if (RSP_RDATA !== exp) begin
      miscompares++;
      $display("FAIL rd_data: addr %h got %h want %h", a, RSP_RDATA, exp);
    end
    vectors++;
    if (REQ_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_ready: got %b want 1", REQ_READY);
    end
  endtask

  task automatic run_bist(input logic [2:0] mode, input int pass_at, input bit with_req);
    int i = 0;
    int end_idx;
    int pass_eff;
    bit exp_ok;
    logic [15:0] a;
    logic [7:0]  d;
    // PASS counts only from the second run cycle; the run ends no later than cycle TMO-1.
    end_idx  = TMO - 1;
    exp_ok   = 1'b0;
    pass_eff = (pass_at < 1) ? 1 : pass_at;
    if (pass_at >= 0 && pass_eff <= TMO - 1) begin
      end_idx = pass_eff;
      exp_ok  = 1'b1;
    end
    a = 16'($urandom);
    d = 8'($urandom);
    wait_ready("bist");
    BIST_REQ = 1'b1; BIST_MODE_IN = mode;
    if (with_req) begin
      REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = a; REQ_WDATA = d;
    end
    #1;
    vectors++;
    if (REQ_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL bist_req_ready: got %b want 0", REQ_READY);
    end
    tick();
    BIST_REQ = 1'b0; BIST_MODE_IN = ~mode;
    while (BIST_EN === 1'b1 && i < 100) begin
      vectors++;
      if ({BIST_MODE, BIST_BUSY, BIST_DONE, REQ_READY, CE, CSB} !== {mode, 5'b10001}) begin
        miscompares++;
        $display("FAIL bist_run: cycle %0d got mode=%h busy=%b done=%b rdy=%b ce=%b csb=%b want %h 1 0 0 0 1",
                 i, BIST_MODE, BIST_BUSY, BIST_DONE, REQ_READY, CE, CSB, mode);
      end
      BIST_REQ  = (i == 2);
      BIST_PASS = (pass_at >= 0 && i >= pass_at);
      tick();
      i++;
    end
    BIST_REQ = 1'b0; BIST_PASS = 1'b0;
    vectors++;
    if (i != end_idx + 1) begin
      miscompares++;
      $display("FAIL bist_len: BIST_EN high %0d cycles want %0d", i, end_idx + 1);
    end
    vectors++;
    if ({BIST_DONE, BIST_OK, BIST_EN, BIST_BUSY, BIST_MODE, REQ_READY} !==
        {1'b1, exp_ok, 2'b00, mode, 1'b0}) begin
      miscompares++;
      $display("FAIL bist_done: got done=%b ok=%b en=%b busy=%b mode=%h rdy=%b want 1 %b 0 0 %h 0",
               BIST_DONE, BIST_OK, BIST_EN, BIST_BUSY, BIST_MODE, REQ_READY, exp_ok, mode);
    end
    tick();
    vectors++;
    if ({BIST_DONE, BIST_OK, BIST_MODE, REQ_READY} !== {1'b0, exp_ok, mode, 1'b1}) begin
      miscompares++;
      $display("FAIL bist_after: got done=%b ok=%b mode=%h rdy=%b want 0 %b %h 1",
               BIST_DONE, BIST_OK, BIST_MODE, REQ_READY, exp_ok, mode);
    end
    if (with_req) begin
      tick();
      REQ_VALID = 1'b0;
      vectors++;
      if ({CE, CSB, WEB, OEB, ADDR, IDATA} !== {4'b1001, a, d}) begin
        miscompares++;
        $display("FAIL bist_coll_wr: got bus=%b addr=%h idata=%h want 1001 %h %h",
                 {CE, CSB, WEB, OEB}, ADDR, IDATA, a, d);
      end
      ref_mem[a] = d;
      ref_wr[a]  = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    logic bad;
    RST = 1'b1;
    tick();
    tick();
    vectors++;
    if ({ADDR, IDATA, CE, CSB, WEB, OEB} !== {16'h0, 8'h0, 4'b0111}) begin
      miscompares++;
      $display("FAIL rst_bus: got addr=%h idata=%h bus=%b want 0000 00 0111", ADDR, IDATA,
               {CE, CSB, WEB, OEB});
    end
    vectors++;
    if ({REQ_READY, RSP_VALID, RSP_RDATA, BIST_EN, BIST_MODE, BIST_BUSY, BIST_DONE, BIST_OK} !==
        17'h0) begin
      miscompares++;
      $display("FAIL rst_ctrl: got rdy=%b rsp=%b rdata=%h en=%b mode=%h busy=%b done=%b ok=%b want all 0",
               REQ_READY, RSP_VALID, RSP_RDATA, BIST_EN, BIST_MODE, BIST_BUSY, BIST_DONE, BIST_OK);
    end
    RST = 1'b0;
    tick();
    vectors++;
    if (REQ_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_ready_idle: got %b want 1", REQ_READY);
    end
    // Abort a write in its bus cycle, asynchronously.
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 16'h0BAD; REQ_WDATA = 8'hEE;
    tick();
    REQ_VALID = 1'b0;
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({ADDR, IDATA, CE, CSB, WEB, OEB, REQ_READY} !== {16'h0, 8'h0, 4'b0111, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_async_wr: got addr=%h idata=%h bus=%b rdy=%b want 0000 00 0111 0", ADDR,
               IDATA, {CE, CSB, WEB, OEB}, REQ_READY);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    tick();
    // Abort a read while waiting for data: no response may follow.
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 16'h0042;
    tick();
    REQ_VALID = 1'b0;
    tick();
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({CE, CSB, WEB, OEB, RSP_VALID} !== 5'b01110) begin
      miscompares++;
      $display("FAIL rst_async_rd: got bus=%b rsp=%b want 0111 0", {CE, CSB, WEB, OEB}, RSP_VALID);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      tick();
      if (RSP_VALID !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL rst_no_rsp: got a response after abort, want none");
    end
    // Abort a BIST run: no DONE may follow.
    BIST_REQ = 1'b1; BIST_MODE_IN = 3'b111;
    tick();
    BIST_REQ = 1'b0;
    tick();
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({BIST_EN, BIST_MODE, BIST_BUSY, BIST_OK} !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_async_bist: got en=%b mode=%h busy=%b ok=%b want 0 0 0 0", BIST_EN,
               BIST_MODE, BIST_BUSY, BIST_OK);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    bad = 1'b0;
    repeat (TMO + 4) begin
      tick();
      if (BIST_DONE !== 1'b0 || BIST_EN !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL rst_no_done: BIST activity after abort, want none");
    end
  endtask

  task automatic test_write();
    do_write(16'h1234, 8'hA5);
    do_write(16'h0000, 8'h5A);
  endtask

  task automatic test_read();
    do_write(16'hFFFF, 8'h3C);
    do_read(16'hFFFF);
    do_read(16'h1234);
    do_read(16'h7777);
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    do_read(16'h00F1);
    do_read(16'h00F2);
    do_write(16'h00F1, 8'h77);
    do_read(16'h00F1);
    vectors++;
    if (cyc - c0 != 3 * (LAT + 3) + 2) begin
      miscompares++;
      $display("FAIL b2b_cycles: got %0d want %0d", cyc - c0, 3 * (LAT + 3) + 2);
    end
  endtask

  task automatic test_bist_pass();
    run_bist(3'b101, 10, 1'b0);
    run_bist(3'b001, 0, 1'b0);
    run_bist(3'b011, TMO - 1, 1'b0);
  endtask

  task automatic test_bist_timeout();
    run_bist(3'b010, -1, 1'b0);
    run_bist(3'b110, TMO, 1'b0);
  endtask

  task automatic test_collision();
    run_bist(3'b100, 5, 1'b1);
    do_read(16'h00F3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      int r;
      int p;
      logic [15:0] a;
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h00F0 + 16'($urandom_range(0, 7));
      if (r < 4) begin
        do_write(a, 8'($urandom));
      end else if (r < 8) begin
        do_read(a);
      end else begin
        p = int'($urandom_range(0, 20)) - 2;
        run_bist(3'($urandom), p, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    BIST_REQ = 1'b0; BIST_MODE_IN = '0; BIST_PASS = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_bist_pass();
    test_bist_timeout();
    test_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
